video_timing_rx: RTL and testbench
==================================

VIDEO_TIMING_RX -- requirements
Module: video_timing_rx

Interface
REQ-001 SHALL have port: clk_sys  in  1  system clock; sole clock; all inputs synchronous to it.
REQ-002 SHALL have port: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port: ce_pix  in  1  pixel enable; all sampling and counting occur only on clk_sys edges with ce_pix=1.
REQ-004 SHALL have ports: hs, vs, de  in  1 each  sync and data-enable stream from the core video generator.
REQ-005 SHALL have ports: h_total, h_active, v_total, v_active  out  12 each  measured pixels/line, active pixels/line, lines/frame, active lines/frame.
REQ-006 SHALL have ports: hs_pol, vs_pol  out  1 each  detected sync polarity (1 = active-low).
REQ-007 SHALL have ports: locked  out  1  timing stable; frame_strobe  out  1  one-clk_sys pulse when measurements update.

Function
REQ-008 SHALL normalise hs/vs to active-high using hs_pol/vs_pol, then detect leading edges against a registered previous sample (ce_pix-qualified).
REQ-009 SHALL count ce_pix samples in a 12-bit h_cnt that is cleared on each hs leading edge; the line length is the sample count from one leading edge up to, but not including, the next.
REQ-010 SHALL count de=1 samples per line into a 12-bit counter; a line is "active" if that count is nonzero.
REQ-011 SHALL count hs leading edges into v_cnt and active lines into va_cnt, both cleared on each vs leading edge.
REQ-012 SHALL implement states SEARCH, MEASURE, LOCKED.
- SEARCH: wait for the first vs leading edge, then go to MEASURE.
- MEASURE: on each vs leading edge, compare the frame's {h_total, v_total} with the previous frame's values; two consecutive equal frames -> LOCKED.
- LOCKED: a mismatch on a vs edge -> MEASURE.
REQ-013 SHALL sample h_total/h_active from the last complete line when a vs leading edge occurs, load all four outputs on that edge, and assert frame_strobe exactly one clk_sys cycle later, in MEASURE and LOCKED only.
REQ-014 SHALL handle counter overflow as follows: any counter reaching 4095 saturates, forces the state to SEARCH, and deasserts locked.
REQ-015 SHALL handle coincident hs and vs leading edges as follows: the line ends before the frame ends, and that line is counted in the frame just closed.
REQ-016 SHALL drive locked=1 only in LOCKED.
REQ-017 SHALL hold all state and outputs when ce_pix=0.

Reset
REQ-018 SHALL, while reset_n=0, clear all counters and outputs to 0 and set the state to SEARCH.
REQ-019 SHALL, on a reset asserted mid-frame, discard the partial measurements; the first frame_strobe comes only after two vs leading edges following reset release.

Configuration
REQ-020 SHALL, with VIDEO_RX_POLARITY_DETECT_EN defined, latch hs_pol/vs_pol as the hs/vs levels sampled on each de rising edge (sync is inactive during active video); a polarity change sends LOCKED to MEASURE.
REQ-021 SHALL, without VIDEO_RX_POLARITY_DETECT_EN, tie hs_pol=vs_pol=0 and treat hs/vs as active-high.

Structure
REQ-022 SHALL place the state enum (SEARCH/MEASURE/LOCKED) and the CNT_W=12 constant in the shared package video_rx_pkg.
REQ-023 SHALL use one sub-module, sync_edge_det, instantiated for hs, vs and de: polarity-normalise, register, and produce a ce_pix-qualified leading-edge pulse.

Verification
REQ-024 SHALL cover: 640x480 timing (800 clk/line, 525 lines, active-high sync, ce_pix=1 always) for 3 frames -> locked=1 after the 2nd vs edge following SEARCH exit; outputs 800/640/525/480.
REQ-025 SHALL cover: the same timing with ce_pix=1 every 4th clock -> identical outputs; frame_strobe width exactly 1 clk_sys.
REQ-026 SHALL cover, with the macro defined: active-low hs/vs -> hs_pol=vs_pol=1 and the same 800/640/525/480 results.
REQ-027 SHALL cover: while locked, one frame of 526 lines -> locked drops at that vs edge, v_total=526; two more 525-line frames -> relock.
REQ-028 SHALL cover: hs held inactive for 5000 samples -> state SEARCH, locked=0, no frame_strobe until resynchronised.
REQ-029 SHALL cover: reset_n pulsed low mid-frame -> all outputs 0 immediately; a valid strobe appears only after two vs edges.

Source files
------------

// File: rtl/video_rx_pkg.sv
// Shared types and constants for the video timing receiver.
package video_rx_pkg;

  localparam int CNT_W = 12;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } rx_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == CNT_MAX) ? x : x + CNT_W'(1);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Polarity-normalises one sync/enable input and flags its leading edge on pixel-enabled samples.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic ce,
  input  logic sig,
  input  logic pol,
  output logic lead
);

  logic level;
  logic prev;

  assign level = sig ^ pol;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 1'b0;
    end else if (ce) begin
      prev <= level;
    end
  end

  assign lead = ce & level & ~prev;

endmodule

// File: rtl/video_timing_rx.sv
// Measures line/frame geometry of an hs/vs/de stream and reports lock.
// Define VIDEO_RX_POLARITY_DETECT_EN to learn sync polarity from the levels seen at de rise.
module video_timing_rx
  import video_rx_pkg::*;
(
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             ce_pix,
  input  logic             hs,
  input  logic             vs,
  input  logic             de,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] v_total,
  output logic [CNT_W-1:0] v_active,
  output logic             hs_pol,
  output logic             vs_pol,
  output logic             locked,
  output logic             frame_strobe
);

  rx_state_t        state, state_next;
  logic [CNT_W-1:0] h_cnt, de_cnt, v_cnt, va_cnt;
  logic [CNT_W-1:0] line_h, line_de;
  logic [CNT_W-1:0] frame_h, frame_ha, frame_v, frame_va;
  logic             hs_lead, vs_lead, de_lead;
  logic             have_prev, video_seen, pol_chg, ovf, match, load;

  sync_edge_det u_hs (.clk(clk_sys), .rst_n(reset_n), .ce(ce_pix), .sig(hs), .pol(hs_pol), .lead(hs_lead));
  sync_edge_det u_vs (.clk(clk_sys), .rst_n(reset_n), .ce(ce_pix), .sig(vs), .pol(vs_pol), .lead(vs_lead));
  sync_edge_det u_de (.clk(clk_sys), .rst_n(reset_n), .ce(ce_pix), .sig(de), .pol(1'b0), .lead(de_lead));

  // SEARCH is only left once active video has been seen, so polarity is settled.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      video_seen <= 1'b0;
    end else if (de_lead) begin
      video_seen <= 1'b1;
    end
  end

`ifdef VIDEO_RX_POLARITY_DETECT_EN
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hs_pol <= 1'b0;
      vs_pol <= 1'b0;
    end else if (de_lead) begin
      hs_pol <= hs;
      vs_pol <= vs;
    end
  end
  assign pol_chg = de_lead & ((hs != hs_pol) | (vs != vs_pol));
`else
  assign hs_pol  = 1'b0;
  assign vs_pol  = 1'b0;
  assign pol_chg = 1'b0;
`endif

  assign ovf = (h_cnt == CNT_MAX) | (de_cnt == CNT_MAX) | (v_cnt == CNT_MAX) | (va_cnt == CNT_MAX);

  // A line ending on the same sample as the frame belongs to the frame being closed.
  always_comb begin
    frame_h  = line_h;
    frame_ha = line_de;
    frame_v  = v_cnt;
    frame_va = va_cnt;
    if (hs_lead) begin
      frame_h  = h_cnt;
      frame_ha = de_cnt;
      frame_v  = sat_inc(v_cnt);
      frame_va = (de_cnt != '0) ? sat_inc(va_cnt) : va_cnt;
    end
  end

  assign match = have_prev && (frame_h == h_total) && (frame_v == v_total);
  assign load  = vs_lead && !ovf && (state != SEARCH);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt   <= '0;
      de_cnt  <= '0;
      v_cnt   <= '0;
      va_cnt  <= '0;
      line_h  <= '0;
      line_de <= '0;
    end else if (ce_pix) begin
      if (hs_lead) begin
        line_h  <= h_cnt;
        line_de <= de_cnt;
        h_cnt   <= CNT_W'(1);
        de_cnt  <= {{(CNT_W-1){1'b0}}, de};
      end else begin
        h_cnt <= sat_inc(h_cnt);
        if (de) begin
          de_cnt <= sat_inc(de_cnt);
        end
      end
      if (vs_lead) begin
        v_cnt  <= '0;
        va_cnt <= '0;
      end else if (hs_lead) begin
        v_cnt  <= frame_v;
        va_cnt <= frame_va;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= SEARCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (ce_pix) begin
      case (state)
        SEARCH:  if (vs_lead && video_seen) state_next = MEASURE;
        MEASURE: if (vs_lead && match) state_next = LOCKED;
        LOCKED:  if ((vs_lead && !match) || pol_chg) state_next = MEASURE;
        default: state_next = SEARCH;
      endcase
      if (ovf) begin
        state_next = SEARCH;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      h_total      <= '0;
      h_active     <= '0;
      v_total      <= '0;
      v_active     <= '0;
      have_prev    <= 1'b0;
      frame_strobe <= 1'b0;
    end else begin
      frame_strobe <= load;
      if (ce_pix && state == SEARCH) begin
        have_prev <= 1'b0;
      end
      if (load) begin
        h_total   <= frame_h;
        h_active  <= frame_ha;
        v_total   <= frame_v;
        v_active  <= frame_va;
        have_prev <= 1'b1;
      end
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_video_timing_rx.sv
// Randomised-geometry bench for video_timing_rx: stimulus pushes expected frame reports, a monitor pops them on frame_strobe.
module tb_video_timing_rx;

  localparam int HS_W = 4;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce_pix  = 1'b0;
  logic        hs = 1'b0, vs = 1'b0, de = 1'b0;
  logic [11:0] h_total, h_active, v_total, v_active;
  logic        hs_pol, vs_pol, locked, frame_strobe;

  video_timing_rx dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce_pix(ce_pix),
    .hs(hs), .vs(vs), .de(de),
    .h_total(h_total), .h_active(h_active), .v_total(v_total), .v_active(v_active),
    .hs_pol(hs_pol), .vs_pol(vs_pol), .locked(locked), .frame_strobe(frame_strobe)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [11:0] ht, ha, vt, va;
    logic        lk, hp, vp;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Stream geometry and reference-model state
  int gh, gha, gv, gva;
  int div = 1;
  bit act_low = 1'b0;
  bit searching = 1'b1;
  bit have_prev = 1'b0;
  int prev_h = 0, prev_v = 0, last_v = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic new_geometry();
    gh  = $urandom_range(48, 30);
    gha = $urandom_range(gh - 8, 8);
    gv  = $urandom_range(22, 14);
    gva = $urandom_range(gv - 4, 6);
    $display("geometry: h=%0d ha=%0d v=%0d va=%0d", gh, gha, gv, gva);
  endtask

  // The frame closed by a vs edge spans the previous vs row up to this one: last_v lines,
  // all gh long, gva of them active, and the line just before vs is active.
  task automatic on_vs();
    exp_t e;
    bit   lk;
    if (searching) begin
      searching = 1'b0;
    end else begin
      lk   = have_prev && (prev_h == gh) && (prev_v == last_v);
      e.ht = 12'(gh);
      e.ha = 12'(gha);
      e.vt = 12'(last_v);
      e.va = 12'(gva);
      e.lk = lk;
      e.hp = act_low;
      e.vp = act_low;
      exp_q.push_back(e);
      prev_h    = gh;
      prev_v    = last_v;
      have_prev = 1'b1;
    end
  endtask

  task automatic pixel(input bit h, input bit v, input bit d);
    for (int k = 0; k < div; k++) begin
      @(negedge clk_sys);
      hs     = h ^ act_low;
      vs     = v ^ act_low;
      de     = d;
      ce_pix = (k == 0);
    end
  endtask

  task automatic mid_reset();
    @(negedge clk_sys);
    reset_n = 1'b0;
    #1;
    chk("midrst_h_total", int'(h_total), 0);
    chk("midrst_h_active", int'(h_active), 0);
    chk("midrst_v_total", int'(v_total), 0);
    chk("midrst_v_active", int'(v_active), 0);
    chk("midrst_locked", int'(locked), 0);
    repeat (3) @(negedge clk_sys);
    reset_n   = 1'b1;
    searching = 1'b1;
    have_prev = 1'b0;
  endtask

  task automatic frame(input int lines, input int rst_row);
    for (int r = 0; r < lines; r++) begin
      for (int p = 0; p < gh; p++) begin
        if (r == rst_row && p == gh / 2) mid_reset();
        if (r == gva && p == 0) on_vs();
        pixel(p < HS_W, (r == gva) || (r == gva + 1), (r < gva) && (p >= gh - gha));
      end
    end
    last_v = lines;
  endtask

  initial begin : monitor
    exp_t e;
    logic prev_s;
    prev_s = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (frame_strobe === 1'b1) begin
        chk("strobe_width", int'(prev_s), 0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_strobe: got strobe (h=%0d v=%0d) expected none", h_total, v_total);
        end else begin
          e = exp_q.pop_front();
          $display("strobe: h_total=%0d h_active=%0d v_total=%0d v_active=%0d locked=%0d pol=%0d/%0d",
                   h_total, h_active, v_total, v_active, locked, hs_pol, vs_pol);
          chk("h_total", int'(h_total), int'(e.ht));
          chk("h_active", int'(h_active), int'(e.ha));
          chk("v_total", int'(v_total), int'(e.vt));
          chk("v_active", int'(v_active), int'(e.va));
          chk("locked", int'(locked), int'(e.lk));
          chk("hs_pol", int'(hs_pol), int'(e.hp));
          chk("vs_pol", int'(vs_pol), int'(e.vp));
        end
      end
      prev_s = frame_strobe;
    end
  end

  initial begin : stimulus
    repeat (4) @(negedge clk_sys);
    #1;
    chk("rst_h_total", int'(h_total), 0);
    chk("rst_h_active", int'(h_active), 0);
    chk("rst_v_total", int'(v_total), 0);
    chk("rst_v_active", int'(v_active), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_strobe", int'(frame_strobe), 0);
    chk("rst_hs_pol", int'(hs_pol), 0);
    chk("rst_vs_pol", int'(vs_pol), 0);
    @(negedge clk_sys);
    reset_n = 1'b1;

    new_geometry();
    repeat (4) frame(gv, -1);
    chk("lock_steady", int'(locked), 1);

    div = 4;
    repeat (3) frame(gv, -1);
    div = 1;
    chk("lock_sparse_ce", int'(locked), 1);

    frame(gv + 1, -1);
    repeat (3) frame(gv, -1);
    chk("relock_after_long_frame", int'(locked), 1);

    searching = 1'b1;
    have_prev = 1'b0;
    for (int i = 0; i < 5000; i++) pixel(1'b0, 1'b0, 1'b0);
    chk("sync_loss_locked", int'(locked), 0);
    new_geometry();
    repeat (4) frame(gv, -1);
    chk("lock_after_resync", int'(locked), 1);

    frame(gv, gva / 2);
    repeat (3) frame(gv, -1);
    chk("lock_after_mid_reset", int'(locked), 1);

`ifdef VIDEO_RX_POLARITY_DETECT_EN
    @(negedge clk_sys);
    reset_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    reset_n   = 1'b1;
    searching = 1'b1;
    have_prev = 1'b0;
    act_low   = 1'b1;
    new_geometry();
    repeat (4) frame(gv, -1);
    chk("lock_active_low", int'(locked), 1);
    chk("hs_pol_active_low", int'(hs_pol), 1);
    chk("vs_pol_active_low", int'(vs_pol), 1);
`endif

    repeat (10) pixel(1'b0, 1'b0, 1'b0);
    chk("pending_strobes", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
